// File: rtl/sram_column_core.sv
//------------------------------------------------------------------------------
// sram_column_core
//
// Clocked, digitised model of one slice of an SRAM array. It holds ROWS x COLS
// bit cells. Each column has a bitline pair (bl/blb) with a precharge and a
// write driver, and a differential sense amplifier. Bitline voltages are
// unsigned VW-bit codes, where VMAX (all ones) stands for VDD.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   rd_wr       0 = write phase (write driver owns the bitlines),
//               1 = read / precharge phase
//   row         word lines; one-hot selects a row, all-zero means idle,
//               more than one bit set is illegal
//   data_in     write data, bit c goes to column c
//   bl_col      registered true-bitline codes, column c in [c*VW +: VW]
//   blb_col     registered complement-bitline codes, same packing
//   preout      sense-amp outputs (read data)
//   sense_valid high while preout holds data resolved in the current read
//   row_err     registered flag, high for each edge that saw an illegal row
//------------------------------------------------------------------------------
module sram_column_core #(
    parameter int COLS     = 1,
    parameter int ROWS     = 4,
    parameter int VW       = 8,
    parameter int STEP     = 32,
    parameter int SENSE_TH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_wr,
    input  logic [ROWS-1:0]      row,
    input  logic [COLS-1:0]      data_in,
    output logic [COLS*VW-1:0]   bl_col,
    output logic [COLS*VW-1:0]   blb_col,
    output logic [COLS-1:0]      preout,
    output logic                 sense_valid,
    output logic                 row_err
);

    localparam logic [VW-1:0] VMAX       = '1;
    localparam logic [VW-1:0] STEP_V     = VW'(STEP);
    localparam logic [VW-1:0] SENSE_TH_V = VW'(SENSE_TH);

    // Kind of word-line activity seen at the current edge.
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ONE,
        ACC_MULTI
    } access_t;

    access_t                     acc;
    logic                        row_multi;
    logic [COLS-1:0]             sel_word;
    logic [COLS-1:0]             resolved;

    logic [ROWS-1:0][COLS-1:0]   cell_q;
    logic [ROWS-1:0][COLS-1:0]   cell_d;
    logic [COLS-1:0][VW-1:0]     bl_q;
    logic [COLS-1:0][VW-1:0]     bl_d;
    logic [COLS-1:0][VW-1:0]     blb_q;
    logic [COLS-1:0][VW-1:0]     blb_d;
    logic [COLS-1:0]             pre_d;
    logic                        sv_d;

    // Discharge by one STEP, clamping at ground instead of wrapping.
    function automatic logic [VW-1:0] sat_sub(input logic [VW-1:0] v);
        return (v >= STEP_V) ? (v - STEP_V) : '0;
    endfunction

    // Unsigned magnitude of the bitline split.
    function automatic logic [VW-1:0] abs_diff(input logic [VW-1:0] a,
                                               input logic [VW-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign bl_col  = bl_q;
    assign blb_col = blb_q;

    // Classify the word lines. Clearing the lowest set bit leaves something
    // behind exactly when more than one line is high, so no popcount is needed.
    always_comb begin
        row_multi = (row & (row - ROWS'(1))) != '0;
        if (row == '0) begin
            acc = ACC_IDLE;
        end else if (row_multi) begin
            acc = ACC_MULTI;
        end else begin
            acc = ACC_ONE;
        end
    end

    // Contents of the selected row. OR-ing the gated rows gives the selected
    // word whenever row is one-hot, and that is the only case that uses it.
    always_comb begin
        sel_word = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row[r]) begin
                sel_word = sel_word | cell_q[r];
            end
        end
    end

    // A column's sense amp can resolve once its registered bitlines have
    // split by at least SENSE_TH.
    always_comb begin
        resolved = '0;
        for (int c = 0; c < COLS; c++) begin
            resolved[c] = abs_diff(bl_q[c], blb_q[c]) >= SENSE_TH_V;
        end
    end

    // Next-state logic for cells, bitlines and sense outputs. Illegal row
    // patterns are treated like idle for the bitlines and never touch the
    // cells. In the write phase the driver forces the bitlines every edge,
    // whether a row is selected or not.
    always_comb begin
        cell_d = cell_q;
        bl_d   = bl_q;
        blb_d  = blb_q;
        pre_d  = preout;
        sv_d   = sense_valid;

        if (!rd_wr) begin
            for (int c = 0; c < COLS; c++) begin
                bl_d[c]  = data_in[c] ? VMAX : '0;
                blb_d[c] = data_in[c] ? '0 : VMAX;
            end
            if (acc == ACC_ONE) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (row[r]) begin
                        cell_d[r] = data_in;
                    end
                end
            end
            sv_d = 1'b0;
        end else if (acc != ACC_ONE) begin
            for (int c = 0; c < COLS; c++) begin
                bl_d[c]  = VMAX;
                blb_d[c] = VMAX;
            end
            sv_d = 1'b0;
        end else begin
            // The side attached to the cell node holding 0 discharges; the
            // sense decision uses the bitlines as they were before this edge.
            for (int c = 0; c < COLS; c++) begin
                if (sel_word[c]) begin
                    blb_d[c] = sat_sub(blb_q[c]);
                end else begin
                    bl_d[c] = sat_sub(bl_q[c]);
                end
                if (resolved[c]) begin
                    pre_d[c] = bl_q[c] > blb_q[c];
                end
            end
            if (&resolved) begin
                sv_d = 1'b1;
            end
        end
    end

    // State registers. Reset clears stored data and leaves the bitlines
    // precharged to VDD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_q      <= '0;
            bl_q        <= '1;
            blb_q       <= '1;
            preout      <= '0;
            sense_valid <= 1'b0;
            row_err     <= 1'b0;
        end else begin
            cell_q      <= cell_d;
            bl_q        <= bl_d;
            blb_q       <= blb_d;
            preout      <= pre_d;
            sense_valid <= sv_d;
            row_err     <= (acc == ACC_MULTI);
        end
    end

endmodule

// File: tb/tb_sram_column_core.sv
//------------------------------------------------------------------------------
// tb_sram_column_core
//
// Self-checking bench for sram_column_core built with four columns and four
// rows. Vectors of {inputs, expected outputs} are queued in a table, driven on
// the falling edge, and checked one time unit after the rising edge through a
// scoreboard queue. Asynchronous reset is exercised by a hand-written sequence.
//------------------------------------------------------------------------------
module tb_sram_column_core;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int VW   = 8;

    logic                 clk;
    logic                 rst;
    logic                 rd_wr;
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      data_in;
    logic [COLS*VW-1:0]   bl_col;
    logic [COLS*VW-1:0]   blb_col;
    logic [COLS-1:0]      preout;
    logic                 sense_valid;
    logic                 row_err;

    int tests_run = 0;
    int tests_failed = 0;
    int step_no = 0;

    typedef struct {
        logic        rd_wr;
        logic [3:0]  row;
        logic [3:0]  din;
        logic [31:0] bl;
        logic [31:0] blb;
        logic [3:0]  pre;
        logic        sv;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    sram_column_core #(
        .COLS(COLS),
        .ROWS(ROWS),
        .VW(VW),
        .STEP(32),
        .SENSE_TH(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_wr(rd_wr),
        .row(row),
        .data_in(data_in),
        .bl_col(bl_col),
        .blb_col(blb_col),
        .preout(preout),
        .sense_valid(sense_valid),
        .row_err(row_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column c gets hi where mask[c] is set, lo elsewhere.
    function automatic logic [31:0] lvl(input logic [3:0] mask,
                                        input logic [7:0] hi,
                                        input logic [7:0] lo);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            v[c*8 +: 8] = mask[c] ? hi : lo;
        end
        return v;
    endfunction

    function automatic void add(input logic rw, input logic [3:0] r,
                                input logic [3:0] d, input logic [31:0] bl,
                                input logic [31:0] blb, input logic [3:0] pre,
                                input logic sv, input logic err);
        vec_t v;
        v.rd_wr = rw; v.row = r; v.din = d;
        v.bl = bl; v.blb = blb; v.pre = pre; v.sv = sv; v.err = err;
        tbl.push_back(v);
    endfunction

    function automatic void add_write(input logic [3:0] r, input logic [3:0] d,
                                      input logic [3:0] pre);
        add(1'b0, r, d, lvl(d, 8'hFF, 8'h00), lvl(d, 8'h00, 8'hFF), pre, 1'b0, 1'b0);
    endfunction

    function automatic void add_pre(input logic [3:0] pre);
        add(1'b1, 4'b0000, 4'b0000, {4{8'hFF}}, {4{8'hFF}}, pre, 1'b0, 1'b0);
    endfunction

    // n read edges on a precharged pair: low side = 255 - 32k clamped at 0,
    // data resolves on the third edge (split of 64 seen before that edge).
    function automatic void add_read(input logic [3:0] r, input logic [3:0] cells,
                                     input int n, input logic [3:0] pre_before);
        int          lv;
        logic [7:0]  low;
        for (int k = 1; k <= n; k++) begin
            lv = 255 - 32 * k;
            if (lv < 0) lv = 0;
            low = 8'(lv);
            add(1'b1, r, 4'b0000, lvl(cells, 8'hFF, low), lvl(cells, low, 8'hFF),
                (k >= 3) ? cells : pre_before, (k >= 3), 1'b0);
        end
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
        end
    endtask

    task automatic check_output();
        vec_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL step %0d scoreboard: got empty queue expected an entry", step_no);
        end else begin
            e = exp_q.pop_front();
            check32("bl_col", bl_col, e.bl);
            check32("blb_col", blb_col, e.blb);
            check32("preout", 32'(preout), 32'(e.pre));
            check32("sense_valid", 32'(sense_valid), 32'(e.sv));
            check32("row_err", 32'(row_err), 32'(e.err));
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rd_wr   = v.rd_wr;
        row     = v.row;
        data_in = v.din;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        check_output();
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            apply_stimulus(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, " bl_col"}, bl_col, {4{8'hFF}});
        check32({tag, " blb_col"}, blb_col, {4{8'hFF}});
        check32({tag, " preout"}, 32'(preout), 32'd0);
        check32({tag, " sense_valid"}, 32'(sense_valid), 32'd0);
        check32({tag, " row_err"}, 32'(row_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rd_wr = 1'b1;
        row = '0;
        data_in = '0;
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle precharge, then single-bit write/precharge/read of row 0.
        add_pre(4'b0000);
        add_write(4'b0001, 4'b0001, 4'b0000);
        add_pre(4'b0000);
        add_read(4'b0001, 4'b0001, 3, 4'b0000);
        add_write(4'b0001, 4'b0000, 4'b0001);
        add_pre(4'b0001);
        add_read(4'b0001, 4'b0000, 3, 4'b0001);
        // Word line drops: bitlines restore, preout holds.
        add_pre(4'b0000);

        // Multi-column patterns in rows 2 and 1, long read saturates at 0.
        add_write(4'b0100, 4'b1010, 4'b0000);
        add_write(4'b0010, 4'b0101, 4'b0000);
        add_pre(4'b0000);
        add_read(4'b0100, 4'b1010, 10, 4'b0000);
        add_pre(4'b1010);
        add_read(4'b0010, 4'b0101, 3, 4'b1010);

        // Illegal row during write: driver still drives, no cell changes.
        add(1'b0, 4'b0011, 4'b1111, {4{8'hFF}}, {4{8'h00}}, 4'b0101, 1'b0, 1'b1);
        add_pre(4'b0101);
        add_read(4'b0001, 4'b0000, 3, 4'b0101);
        add_pre(4'b0000);
        add_read(4'b0010, 4'b0101, 3, 4'b0000);
        // Illegal row during read phase behaves as precharge.
        add(1'b1, 4'b0110, 4'b0000, {4{8'hFF}}, {4{8'hFF}}, 4'b0101, 1'b0, 1'b1);
        add_pre(4'b0101);
        add_read(4'b0010, 4'b0101, 1, 4'b0101);
        run_table();

        // Reset on the second edge of a read: immediate return to reset state.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        @(posedge clk);
        #1;
        check_reset_values("held reset");
        @(negedge clk);
        rst = 1'b0;

        // Stored data is lost: every row now reads 0.
        add_pre(4'b0000);
        add_read(4'b0010, 4'b0000, 3, 4'b0000);
        add_pre(4'b0000);
        add_read(4'b0100, 4'b0000, 3, 4'b0000);
        run_table();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_column_core.md
Name: sram_column_core

Overview:
- Clocked, digitised model of an SRAM array slice: bit-cell storage (sram_cell), per-column bitline precharge (precharge) and differential sense amplifiers (sense_amp).
- Bitline voltages are unsigned VW-bit codes; VMAX = 2^VW-1 represents VDD.
- Sits between the row decoder / write driver and the read-data path.
- Write data enters on data_in. Read data leaves on preout.

Parameters:
- COLS, 1, number of columns (bits per word).
- ROWS, 4, number of word lines / cells per column.
- VW, 8, bitline code width; VMAX = 2^VW-1.
- STEP, 32, bitline discharge per clock when a cell storing 0 is selected during read.
- SENSE_TH, 64, minimum |bl-blb| needed to resolve the sense amp (SENSE_TH <= VMAX).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_wr  in  1  0 = write phase (write-driver drives bitlines), 1 = read/precharge phase.
- row  in  ROWS  word lines; one-hot selects a cell row, all-zero means idle.
- data_in  in  COLS  write data, bit c goes to column c.
- bl_col  out  COLS*VW  registered true-bitline codes, column c in bits [c*VW +: VW].
- blb_col  out  COLS*VW  registered complement-bitline codes, same packing.
- preout  out  COLS  sense-amp output (read data).
- sense_valid  out  1  high while preout holds data resolved in the current read access.
- row_err  out  1  registered flag, high for each cycle in which row had more than one bit set.

Behaviour:
- Reset (async, while rst=1):
  - all cells = 0
  - bl_col = blb_col = VMAX for every column
  - preout = 0, sense_valid = 0, row_err = 0
- Access classification each edge:
  - row == 0 → idle
  - popcount(row) == 1 → access
  - popcount(row) > 1 → illegal. No cell changes. Bitlines behave as idle. row_err = 1 that cycle, otherwise 0.
- Write, rd_wr=0:
  - Every edge: bl <= data_in[c] ? VMAX : 0 and blb <= complement, whether row is set or not.
  - On an access edge, cell[sel][c] <= data_in[c]. Single-cycle write latency.
  - sense_valid <= 0; preout holds.
- Precharge, rd_wr=1 and idle:
  - bl <= VMAX and blb <= VMAX each edge.
  - Full restore takes one cycle.
  - sense_valid <= 0; preout holds.
- Read, rd_wr=1 and access:
  - Cells are unchanged (non-destructive read).
  - Per column, the side whose node stores 0 discharges by STEP per edge, saturating at 0:
    - cell=1: blb discharges, bl stays.
    - cell=0: bl discharges, blb stays.
  - The other side is held at its current value.
- Sense evaluation, per column, on every read-access edge, using the registered bitline values before the edge:
  - If |bl-blb| >= SENSE_TH: preout[c] <= (bl > blb), and sense_valid <= 1 once all columns resolve.
  - Otherwise preout[c] and sense_valid hold their values.
- Read latency with defaults, bitlines precharged before the word line rises:
  - edge 1: low side = 223
  - edge 2: low side = 191, difference 64
  - edge 3: preout valid, sense_valid = 1
  - General: ceil(SENSE_TH/STEP)+1 edges.
- Word line drops mid-read: the next edge precharges; sense_valid <= 0; preout keeps its last value.
- rd_wr toggles mid-access: the new phase applies from the next edge. A read that follows a write without a precharge cycle evaluates the write-driven levels, which is legal but not required behaviour.
- Reset asserted mid-operation: immediate return to reset values; stored data is lost.
- Arithmetic: saturating subtraction only, no wrap-around. Comparisons are unsigned.

Test Plan:
- Reset, then rd_wr=1, row=0 for 1 cycle → bl_col = blb_col = 255, preout = 0, sense_valid = 0.
- Write data_in=1 to row=0001 (1 cycle), precharge 1 cycle, read row=0001 → blb falls 223 then 191, bl stays 255, preout=1 and sense_valid=1 on the 3rd edge.
- Write data_in=0 to the same row, precharge, read → bl falls, preout=0 on the 3rd edge. Then drop row → bitlines return to 255 next edge, preout stays 0, sense_valid=0.
- COLS=4, ROWS=4: write 1010 to row 2 and 0101 to row 1. Read row 2 → preout=1010; read row 1 → preout=0101. Hold read 10 cycles → low side saturates at 0, no wrap.
- row=0011 during write with data_in=1 → row_err=1 that cycle, no cell changes; subsequent reads of rows 0 and 1 return their prior values.
- Assert rst on the 2nd edge of a read → bitlines = 255, preout = 0, sense_valid = 0 immediately; a later read of any row returns 0.
